// File: rtl/sd_card_fsm_if.sv
// Command/response/data-strobe bundle between the SD CMD receiver, this responder and the DAT engine.
interface sd_card_fsm_if;
    logic         icmd_valid;
    logic [5:0]   icmd_index;
    logic [31:0]  icmd_arg;
    logic         icrc_ok;
    logic         iresp_ready;
    logic         iprog_done;
    logic         oresp_valid;
    logic [2:0]   oresp_type;
    logic [119:0] oresp;
    logic         ord_start;
    logic         owr_start;
    logic         ostat_start;
    logic         odata_stop;
    logic [31:0]  oaddr;
    logic [3:0]   ocard_state;

    modport master (
        output icmd_valid, icmd_index, icmd_arg, icrc_ok, iresp_ready, iprog_done,
        input  oresp_valid, oresp_type, oresp, ord_start, owr_start, ostat_start,
        input  odata_stop, oaddr, ocard_state
    );

    modport slave (
        input  icmd_valid, icmd_index, icmd_arg, icrc_ok, iresp_ready, iprog_done,
        output oresp_valid, oresp_type, oresp, ord_start, owr_start, ostat_start,
        output odata_stop, oaddr, ocard_state
    );
endinterface

// File: rtl/sd_card_fsm.sv
// Card-side SD command responder: card state, RCA, APP_CMD context and R1/R2/R3/R6/R7 generation.
// Define SD_CARD_CRC_CHECK_EN to refuse execution of commands whose CRC7 check failed.
module sd_card_fsm #(
    parameter logic [15:0] RCA_VAL     = 16'h1234,
    parameter int          BUSY_CNT    = 2,
    parameter int          NCR         = 2,
    parameter logic [3:0]  READ_BL_LEN = 4'd9,
    parameter logic [11:0] C_SIZE      = 12'd1023,
    parameter logic [2:0]  C_SIZE_MULT = 3'd7
) (
    input  logic         iclk,
    input  logic         irst,
    sd_card_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_READY = 4'd1,
        ST_IDENT = 4'd2,
        ST_STBY  = 4'd3,
        ST_TRAN  = 4'd4,
        ST_DATA  = 4'd5,
        ST_RCV   = 4'd6,
        ST_PRG   = 4'd7,
        ST_INA   = 4'd15
    } state_t;

    localparam logic [2:0]   RT_NONE = 3'd0;
    localparam logic [2:0]   RT_R1   = 3'd1;
    localparam logic [2:0]   RT_R2   = 3'd2;
    localparam logic [2:0]   RT_R3   = 3'd3;
    localparam logic [2:0]   RT_R6   = 3'd6;
    localparam logic [2:0]   RT_R7   = 3'd7;
    localparam logic [3:0]   NCR_L   = 4'(NCR);
    localparam logic [7:0]   BUSY_L  = 8'(BUSY_CNT);
    localparam logic [32:0]  CAP_BLOCKS = (33'(C_SIZE) + 33'd1) << (int'(C_SIZE_MULT) + 2);
    localparam logic [119:0] CID_WORD = 120'h01;
    localparam logic [119:0] CSD_WORD = (120'(READ_BL_LEN) << 72) | (120'(C_SIZE) << 54)
                                      | (120'(C_SIZE_MULT) << 39);

    state_t         state_q, state_d;
    logic [15:0]    rca_q, rca_d;
    logic           app_q, app_d;
    logic [7:0]     busy_q, busy_d;
    logic           ill_q, ill_d;
    logic           crc_q, crc_d;
    logic [22:0]    blk_q, blk_d;
    logic [31:0]    addr_q, addr_d;
    logic           resp_valid_q, resp_valid_d;
    logic [2:0]     resp_type_q, resp_type_d;
    logic [119:0]   resp_q, resp_d;
    logic [3:0]     ncr_q, ncr_d;
    logic           rd_start_q, rd_start_d;
    logic           wr_start_q, wr_start_d;
    logic           stat_start_q, stat_start_d;
    logic           stop_q, stop_d;

    logic           accept, addressed, crc_bad;
    logic           r1_req, oor, illegal;
    logic           exec_rd, exec_wr, exec_stat, exec_stop;
    logic [2:0]     exec_type;
    logic [119:0]   exec_payload;

    // A response still counting down NCR or awaiting iresp_ready blocks new commands.
    assign accept = bus.icmd_valid && !resp_valid_q && (ncr_q == 4'd0);

    assign addressed = (bus.icmd_index == 6'd7)  || (bus.icmd_index == 6'd9) ||
                       (bus.icmd_index == 6'd13) || (bus.icmd_index == 6'd15) ||
                       (bus.icmd_index == 6'd55);

`ifdef SD_CARD_CRC_CHECK_EN
    assign crc_bad = ~bus.icrc_ok;
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q      <= ST_IDLE;
            rca_q        <= '0;
            app_q        <= 1'b0;
            busy_q       <= '0;
            ill_q        <= 1'b0;
            crc_q        <= 1'b0;
            blk_q        <= '0;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_type_q  <= RT_NONE;
            resp_q       <= '0;
            ncr_q        <= '0;
            rd_start_q   <= 1'b0;
            wr_start_q   <= 1'b0;
            stat_start_q <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rca_q        <= rca_d;
            app_q        <= app_d;
            busy_q       <= busy_d;
            ill_q        <= ill_d;
            crc_q        <= crc_d;
            blk_q        <= blk_d;
            addr_q       <= addr_d;
            resp_valid_q <= resp_valid_d;
            resp_type_q  <= resp_type_d;
            resp_q       <= resp_d;
            ncr_q        <= ncr_d;
            rd_start_q   <= rd_start_d;
            wr_start_q   <= wr_start_d;
            stat_start_q <= stat_start_d;
            stop_q       <= stop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rca_d        = rca_q;
        app_d        = app_q;
        busy_d       = busy_q;
        ill_d        = ill_q;
        crc_d        = crc_q;
        blk_d        = blk_q;
        addr_d       = addr_q;
        exec_type    = RT_NONE;
        exec_payload = '0;
        exec_rd      = 1'b0;
        exec_wr      = 1'b0;
        exec_stat    = 1'b0;
        exec_stop    = 1'b0;
        r1_req       = 1'b0;
        oor          = 1'b0;
        illegal      = 1'b0;

        if (accept && state_q != ST_INA) begin
            if (crc_bad) begin
                crc_d = 1'b1;
            end else if (addressed && bus.icmd_arg[31:16] != rca_q) begin
                app_d = 1'b0;
            end else begin
                app_d = 1'b0;
                case (bus.icmd_index)
                    6'd0: begin
                        state_d = ST_IDLE;
                        rca_d   = '0;
                        busy_d  = '0;
                    end
                    6'd8: begin
                        if (state_q == ST_IDLE) begin
                            exec_type    = RT_R7;
                            exec_payload = {88'd0, 20'd0, bus.icmd_arg[11:0]};
                        end else illegal = 1'b1;
                    end
                    6'd55: begin
                        app_d  = 1'b1;
                        r1_req = 1'b1;
                    end
                    6'd41: begin
                        if (app_q && state_q == ST_IDLE) begin
                            if (bus.icmd_arg[21:20] == 2'b00) begin
                                state_d = ST_INA;
                            end else if (busy_q >= BUSY_L) begin
                                exec_type    = RT_R3;
                                exec_payload = {88'd0, 1'b1, 9'd0, 2'b11, 20'd0};
                                state_d      = ST_READY;
                            end else begin
                                exec_type    = RT_R3;
                                exec_payload = {88'd0, 1'b0, 9'd0, 2'b11, 20'd0};
                                busy_d       = busy_q + 8'd1;
                            end
                        end else illegal = 1'b1;
                    end
                    6'd2: begin
                        if (state_q == ST_READY) begin
                            exec_type    = RT_R2;
                            exec_payload = CID_WORD;
                            state_d      = ST_IDENT;
                        end else illegal = 1'b1;
                    end
                    6'd3: begin
                        if (state_q == ST_IDENT) begin
                            exec_type    = RT_R6;
                            exec_payload = {88'd0, RCA_VAL, 16'h0500};
                            rca_d        = RCA_VAL;
                            state_d      = ST_STBY;
                        end else illegal = 1'b1;
                    end
                    6'd9: begin
                        if (state_q == ST_STBY) begin
                            exec_type    = RT_R2;
                            exec_payload = CSD_WORD;
                        end else illegal = 1'b1;
                    end
                    6'd7: begin
                        if (state_q == ST_STBY) begin
                            r1_req  = 1'b1;
                            state_d = ST_TRAN;
                        end else illegal = 1'b1;
                    end
                    6'd6: begin
                        if (state_q == ST_TRAN) begin
                            r1_req    = 1'b1;
                            exec_stat = 1'b1;
                        end else illegal = 1'b1;
                    end
                    6'd23: begin
                        if (app_q && state_q == ST_TRAN) begin
                            r1_req = 1'b1;
                            blk_d  = bus.icmd_arg[22:0];
                        end else illegal = 1'b1;
                    end
                    6'd18: begin
                        if (state_q != ST_TRAN) begin
                            illegal = 1'b1;
                        end else if ({1'b0, bus.icmd_arg} >= CAP_BLOCKS) begin
                            r1_req = 1'b1;
                            oor    = 1'b1;
                        end else begin
                            r1_req  = 1'b1;
                            addr_d  = bus.icmd_arg;
                            exec_rd = 1'b1;
                            state_d = ST_DATA;
                        end
                    end
                    6'd25: begin
                        if (state_q == ST_TRAN) begin
                            r1_req  = 1'b1;
                            addr_d  = bus.icmd_arg;
                            exec_wr = 1'b1;
                            state_d = ST_RCV;
                        end else illegal = 1'b1;
                    end
                    6'd12: begin
                        if (state_q == ST_DATA || state_q == ST_RCV) begin
                            r1_req    = 1'b1;
                            exec_stop = 1'b1;
                            state_d   = (state_q == ST_DATA) ? ST_TRAN : ST_PRG;
                        end else illegal = 1'b1;
                    end
                    6'd13: begin
                        if (state_q inside {ST_STBY, ST_TRAN, ST_DATA, ST_RCV, ST_PRG}) r1_req = 1'b1;
                        else illegal = 1'b1;
                    end
                    6'd15: state_d = ST_INA;
                    default: illegal = 1'b1;
                endcase
            end
        end

        if (illegal) ill_d = 1'b1;

        // Status reflects the state at accept time; reporting consumes the sticky error bits.
        if (r1_req) begin
            exec_type    = RT_R1;
            exec_payload = {88'd0, oor, 7'd0, crc_q, ill_q, 9'd0, state_q,
                            (state_q != ST_PRG), 2'b00,
                            (app_q || bus.icmd_index == 6'd55), 5'd0};
            ill_d        = 1'b0;
            crc_d        = 1'b0;
        end

        // Programming completion is applied after the command has been judged against PRG.
        if (state_q == ST_PRG && state_d == ST_PRG && bus.iprog_done) state_d = ST_TRAN;
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_type_d  = resp_type_q;
        resp_d       = resp_q;
        ncr_d        = ncr_q;
        rd_start_d   = exec_rd;
        wr_start_d   = exec_wr;
        stat_start_d = exec_stat;
        stop_d       = exec_stop;

        if (resp_valid_q && bus.iresp_ready) resp_valid_d = 1'b0;
        if (ncr_q != 4'd0) begin
            ncr_d = ncr_q - 4'd1;
            if (ncr_q == 4'd1) resp_valid_d = 1'b1;
        end
        if (exec_type != RT_NONE) begin
            resp_type_d = exec_type;
            resp_d      = exec_payload;
            ncr_d       = NCR_L;
        end
    end

    assign bus.oresp_valid = resp_valid_q;
    assign bus.oresp_type  = resp_valid_q ? resp_type_q : RT_NONE;
    assign bus.oresp       = resp_valid_q ? resp_q : '0;
    assign bus.ord_start   = rd_start_q;
    assign bus.owr_start   = wr_start_q;
    assign bus.ostat_start = stat_start_q;
    assign bus.odata_stop  = stop_q;
    assign bus.oaddr       = addr_q;
    assign bus.ocard_state = state_q;

endmodule

// File: tb/tb_sd_card_fsm.sv
// Directed bench for sd_card_fsm: init sequence, addressing, read/write flows, errors and handshake hold.
module tb_sd_card_fsm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_card_fsm_if bus();

    sd_card_fsm dut (
        .iclk (clk),
        .irst (rst),
        .bus  (bus)
    );

    typedef struct {
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   prog;    // 1: iprog_done pulse before command, 2: coincident with command
        logic [2:0]   etype;
        logic [119:0] eresp;
        logic [3:0]   estrb;   // {rd, wr, stat, stop}
        logic [3:0]   estate;
        logic [31:0]  eaddr;
    } vec_t;

    localparam logic [119:0] CSD_E = (120'd9 << 72) | (120'd1023 << 54) | (120'd7 << 39);
    localparam logic [31:0]  A_RCA = 32'h1234_0000;
    localparam logic [31:0]  A_BAD = 32'h0001_0000;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    logic [3:0]   strb_a, strb_b, state_a;
    logic [31:0]  addr_a;
    logic         v_early, v_on, v_after;
    logic [2:0]   typ;
    logic [119:0] pay;

    function automatic logic [119:0] w(input logic [31:0] x);
        return {88'd0, x};
    endfunction

    function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] prog,
                                input logic [2:0] etype, input logic [119:0] eresp,
                                input logic [3:0] estrb, input logic [3:0] estate, input logic [31:0] eaddr);
        vec_t v;
        v.idx = idx; v.arg = arg; v.prog = prog; v.etype = etype; v.eresp = eresp;
        v.estrb = estrb; v.estate = estate; v.eaddr = eaddr;
        return v;
    endfunction

    function automatic logic [3:0] strobes();
        return {bus.ord_start, bus.owr_start, bus.ostat_start, bus.odata_stop};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] prog);
        if (prog == 2'd1) begin
            @(negedge clk); bus.iprog_done = 1'b1;
            @(negedge clk); bus.iprog_done = 1'b0;
        end
        @(negedge clk);
        bus.icmd_valid = 1'b1;
        bus.icmd_index = idx;
        bus.icmd_arg   = arg;
        bus.iprog_done = (prog == 2'd2);
        @(posedge clk); #1;
        strb_a  = strobes();
        state_a = bus.ocard_state;
        addr_a  = bus.oaddr;
        @(negedge clk);
        bus.icmd_valid = 1'b0;
        bus.iprog_done = 1'b0;
        @(posedge clk); #1;
        strb_b  = strobes();
        v_early = bus.oresp_valid;
        @(posedge clk); #1;
        v_on = bus.oresp_valid;
        typ  = bus.oresp_type;
        pay  = bus.oresp;
        v_after = 1'b0;
        if (v_on) begin
            @(negedge clk); bus.iresp_ready = 1'b1;
            @(posedge clk); #1;
            v_after = bus.oresp_valid;
            @(negedge clk); bus.iresp_ready = 1'b0;
        end else begin
            repeat (2) @(posedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic         stable, saw_rd;
        logic [2:0]   ty0;
        logic [119:0] pay0;

        bus.icmd_valid = 1'b0; bus.icmd_index = '0; bus.icmd_arg = '0;
        bus.icrc_ok = 1'b1; bus.iresp_ready = 1'b0; bus.iprog_done = 1'b0;
        rst = 1'b1;

        vecs.push_back(mk(6'd8,  32'h1AA,      0, 3'd7, w(32'h0000_01AA), 4'b0000, 4'd0,  32'h0));
        vecs.push_back(mk(6'd55, 32'h0,        0, 3'd1, w(32'h0000_0120), 4'b0000, 4'd0,  32'h0));
        vecs.push_back(mk(6'd41, 32'h8030_0000,0, 3'd3, w(32'h0030_0000), 4'b0000, 4'd0,  32'h0));
        vecs.push_back(mk(6'd55, 32'h0,        0, 3'd1, w(32'h0000_0120), 4'b0000, 4'd0,  32'h0));
        vecs.push_back(mk(6'd41, 32'h8030_0000,0, 3'd3, w(32'h0030_0000), 4'b0000, 4'd0,  32'h0));
        vecs.push_back(mk(6'd55, 32'h0,        0, 3'd1, w(32'h0000_0120), 4'b0000, 4'd0,  32'h0));
        vecs.push_back(mk(6'd41, 32'h8030_0000,0, 3'd3, w(32'h8030_0000), 4'b0000, 4'd1,  32'h0));
        vecs.push_back(mk(6'd2,  32'h0,        0, 3'd2, w(32'h0000_0001), 4'b0000, 4'd2,  32'h0));
        vecs.push_back(mk(6'd3,  32'h0,        0, 3'd6, w(32'h1234_0500), 4'b0000, 4'd3,  32'h0));
        vecs.push_back(mk(6'd9,  A_BAD,        0, 3'd0, w(32'h0),         4'b0000, 4'd3,  32'h0));
        vecs.push_back(mk(6'd9,  A_RCA,        0, 3'd2, CSD_E,            4'b0000, 4'd3,  32'h0));
        vecs.push_back(mk(6'd25, 32'h0,        0, 3'd0, w(32'h0),         4'b0000, 4'd3,  32'h0));
        vecs.push_back(mk(6'd13, A_RCA,        0, 3'd1, w(32'h0040_0700), 4'b0000, 4'd3,  32'h0));
        vecs.push_back(mk(6'd13, A_RCA,        0, 3'd1, w(32'h0000_0700), 4'b0000, 4'd3,  32'h0));
        vecs.push_back(mk(6'd7,  A_BAD,        0, 3'd0, w(32'h0),         4'b0000, 4'd3,  32'h0));
        vecs.push_back(mk(6'd7,  A_RCA,        0, 3'd1, w(32'h0000_0700), 4'b0000, 4'd4,  32'h0));
        vecs.push_back(mk(6'd18, 32'h5,        0, 3'd1, w(32'h0000_0900), 4'b1000, 4'd5,  32'h5));
        vecs.push_back(mk(6'd12, 32'h0,        0, 3'd1, w(32'h0000_0B00), 4'b0001, 4'd4,  32'h5));
        vecs.push_back(mk(6'd18, 32'h0008_0000,0, 3'd1, w(32'h8000_0900), 4'b0000, 4'd4,  32'h5));
        vecs.push_back(mk(6'd55, A_RCA,        0, 3'd1, w(32'h0000_0920), 4'b0000, 4'd4,  32'h5));
        vecs.push_back(mk(6'd23, 32'h8,        0, 3'd1, w(32'h0000_0920), 4'b0000, 4'd4,  32'h5));
        vecs.push_back(mk(6'd25, 32'h100,      0, 3'd1, w(32'h0000_0900), 4'b0100, 4'd6,  32'h100));
        vecs.push_back(mk(6'd12, 32'h0,        0, 3'd1, w(32'h0000_0D00), 4'b0001, 4'd7,  32'h100));
        vecs.push_back(mk(6'd13, A_RCA,        0, 3'd1, w(32'h0000_0E00), 4'b0000, 4'd7,  32'h100));
        vecs.push_back(mk(6'd13, A_RCA,        1, 3'd1, w(32'h0000_0900), 4'b0000, 4'd4,  32'h100));
        vecs.push_back(mk(6'd25, 32'h200,      0, 3'd1, w(32'h0000_0900), 4'b0100, 4'd6,  32'h200));
        vecs.push_back(mk(6'd12, 32'h0,        0, 3'd1, w(32'h0000_0D00), 4'b0001, 4'd7,  32'h200));
        vecs.push_back(mk(6'd13, A_RCA,        2, 3'd1, w(32'h0000_0E00), 4'b0000, 4'd4,  32'h200));
        vecs.push_back(mk(6'd6,  32'h0,        0, 3'd1, w(32'h0000_0900), 4'b0010, 4'd4,  32'h200));

        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", 128'(bus.oresp_valid), 128'(0));
        chk("reset type",  128'(bus.oresp_type),  128'(0));
        chk("reset state", 128'(bus.ocard_state), 128'(0));
        chk("reset outs",  128'({strobes(), bus.oaddr, bus.oresp}), 128'(0));
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            do_cmd(v.idx, v.arg, v.prog);
            $display("cmd%0d arg=%08h -> valid=%0b type=%0d resp=%08h state=%0d",
                     v.idx, v.arg, v_on, typ, pay[31:0], state_a);
            chk($sformatf("v%0d early", i),   128'(v_early), 128'(0));
            chk($sformatf("v%0d valid", i),   128'(v_on),    128'(v.etype != 3'd0));
            if (v.etype != 3'd0) begin
                chk($sformatf("v%0d type", i),    128'(typ),     128'(v.etype));
                chk($sformatf("v%0d payload", i), 128'(pay),     128'(v.eresp));
                chk($sformatf("v%0d release", i), 128'(v_after), 128'(0));
            end
            chk($sformatf("v%0d strobe", i),  128'(strb_a),  128'(v.estrb));
            chk($sformatf("v%0d pulse", i),   128'(strb_b),  128'(0));
            chk($sformatf("v%0d state", i),   128'(state_a), 128'(v.estate));
            chk($sformatf("v%0d addr", i),    128'(addr_a),  128'(v.eaddr));
        end

        // Response held with iresp_ready low; a command arriving meanwhile must be dropped.
        @(negedge clk);
        bus.icmd_valid = 1'b1; bus.icmd_index = 6'd13; bus.icmd_arg = A_RCA;
        @(negedge clk);
        bus.icmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("hold valid", 128'(bus.oresp_valid), 128'(1));
        ty0 = bus.oresp_type;
        pay0 = bus.oresp;
        chk("hold payload", 128'({ty0, pay0}), 128'({3'd1, w(32'h0000_0900)}));
        @(negedge clk);
        bus.icmd_valid = 1'b1; bus.icmd_index = 6'd18; bus.icmd_arg = 32'h5;
        @(negedge clk);
        bus.icmd_valid = 1'b0;
        stable = 1'b1;
        saw_rd = 1'b0;
        for (int h = 0; h < 10; h++) begin
            @(posedge clk); #1;
            if (!bus.oresp_valid || bus.oresp_type != ty0 || bus.oresp != pay0) stable = 1'b0;
            if (bus.ord_start) saw_rd = 1'b1;
        end
        $display("hold: stable=%0b dropped_cmd_started=%0b", stable, saw_rd);
        chk("hold stable", 128'(stable), 128'(1));
        chk("drop no read", 128'(saw_rd), 128'(0));
        @(negedge clk); bus.iresp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold release", 128'(bus.oresp_valid), 128'(0));
        @(negedge clk); bus.iresp_ready = 1'b0;
        chk("drop state", 128'(bus.ocard_state), 128'(4));
        chk("drop addr",  128'(bus.oaddr), 128'(32'h200));

        // CMD0 clears RCA, then ACMD41 with no voltage window parks the card in INA.
        do_cmd(6'd0, 32'h0, 0);
        $display("cmd0 -> valid=%0b state=%0d", v_on, state_a);
        chk("cmd0 valid", 128'(v_on), 128'(0));
        chk("cmd0 state", 128'(state_a), 128'(0));
        do_cmd(6'd55, 32'h0, 0);
        $display("cmd55 -> valid=%0b resp=%08h", v_on, pay[31:0]);
        chk("cmd55 rca0", 128'({v_on, pay}), 128'({1'b1, w(32'h0000_0120)}));
        do_cmd(6'd41, 32'h0, 0);
        $display("acmd41 arg0 -> valid=%0b state=%0d", v_on, state_a);
        chk("acmd41 ina valid", 128'(v_on), 128'(0));
        chk("acmd41 ina state", 128'(state_a), 128'(15));
        do_cmd(6'd0, 32'h0, 0);
        $display("cmd0 in INA -> state=%0d", state_a);
        chk("ina cmd0", 128'(state_a), 128'(15));
        do_cmd(6'd8, 32'h1AA, 0);
        $display("cmd8 in INA -> valid=%0b", v_on);
        chk("ina cmd8", 128'(v_on), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
